avalon_bus_arbiter: RTL and testbench

//  Shares one Avalon-MM master port between NUM_REQ requesters (e.g. fetch, load/store, debug).

---
 rtl/avalon_bus_arbiter_pkg.sv | 21 ++
 rtl/avalon_rr_picker.sv | 41 ++++
 rtl/avalon_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the Avalon-MM bus arbiter.
//   avalon_arb_state_t : arbiter FSM state (idle / bus transaction in flight)
//   AVALON_ARB_*       : bus widths and the requester-count ceiling
package avalon_bus_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUS  = 1'b1
  } avalon_arb_state_t;

  localparam int AVALON_ARB_MAX_REQ = 8;
  localparam int AVALON_ARB_DATA_W  = 32;
  localparam int AVALON_ARB_BE_W    = 4;
  localparam int AVALON_ARB_WAIT_W  = 16;

  // Width of a requester index; at least one bit even for tiny configurations.
  function automatic int arb_idx_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/avalon_rr_picker.sv
// Combinational round-robin picker.
//   i_req        : request vector
//   i_last_grant : index of the requester served most recently
//   o_grant      : one-hot winner (all zero when no request)
//   o_idx        : binary index of the winner
//   o_any        : at least one request present
// The scan starts one past i_last_grant and wraps, so the requester just
// served has the lowest priority.
module avalon_rr_picker
  import avalon_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    logic [IDX_W-1:0] w_j;
    logic             w_found;
    w_j     = '0;
    w_found = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between NUM_REQ
// requesters. One transaction in flight; read data is taken on
// read & ~waitrequest (no readdatavalid).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req/req_load          : per-requester valid and 1=read/0=write
//   req_addr/be/wdata     : per-requester packed address, byte enables, data
//   grant                 : combinational one-hot accept (only in IDLE)
//   rsp_valid/rsp_data    : one-cycle completion pulse to owner, read data
//   timeout_err           : sticky abort flag
//   avm_*                 : Avalon-MM master signals
// Optional feature: define AVALON_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES waitrequest cycles; otherwise the bus waits indefinitely and
// timeout_err is tied low.
module avalon_bus_arbiter
  import avalon_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0]                     req_load,
  input  logic [NUM_REQ*AVALON_ARB_DATA_W-1:0]   req_addr,
  input  logic [NUM_REQ*AVALON_ARB_BE_W-1:0]     req_be,
  input  logic [NUM_REQ*AVALON_ARB_DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                     grant,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic [AVALON_ARB_DATA_W-1:0]           rsp_data,
  output logic                                   timeout_err,
  output logic [AVALON_ARB_DATA_W-1:0]           avm_address,
  output logic [AVALON_ARB_BE_W-1:0]             avm_byteenable,
  output logic [AVALON_ARB_DATA_W-1:0]           avm_writedata,
  output logic                                   avm_read,
  output logic                                   avm_write,
  input  logic [AVALON_ARB_DATA_W-1:0]           avm_readdata,
  input  logic                                   avm_waitrequest
);

  localparam int IDX_W = arb_idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > AVALON_ARB_MAX_REQ) begin : g_bad_num_req
    $error("avalon_bus_arbiter: NUM_REQ out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << AVALON_ARB_WAIT_W)) begin : g_bad_timeout
    $error("avalon_bus_arbiter: TIMEOUT_CYCLES out of range");
  end

  avalon_arb_state_t                r_state;
  avalon_arb_state_t                w_next_state;
  logic [IDX_W-1:0]                 r_owner;
  logic [IDX_W-1:0]                 r_last_grant;
  logic                             r_read;
  logic                             r_write;
  logic [NUM_REQ-1:0]               r_rsp_valid;
  logic [AVALON_ARB_DATA_W-1:0]     r_rsp_data;
  logic [AVALON_ARB_DATA_W-1:0]     r_addr;
  logic [AVALON_ARB_BE_W-1:0]       r_be;
  logic [AVALON_ARB_DATA_W-1:0]     r_wdata;

  logic [NUM_REQ-1:0]               w_pick_grant;
  logic [IDX_W-1:0]                 w_pick_idx;
  logic                             w_req_any;
  logic                             w_accept;
  logic                             w_done;
  logic                             w_abort;

  logic [AVALON_ARB_DATA_W-1:0]     w_addr_arr  [NUM_REQ];
  logic [AVALON_ARB_BE_W-1:0]       w_be_arr    [NUM_REQ];
  logic [AVALON_ARB_DATA_W-1:0]     w_wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*AVALON_ARB_DATA_W +: AVALON_ARB_DATA_W];
    assign w_be_arr[g]    = req_be[g*AVALON_ARB_BE_W +: AVALON_ARB_BE_W];
    assign w_wdata_arr[g] = req_wdata[g*AVALON_ARB_DATA_W +: AVALON_ARB_DATA_W];
  end

  avalon_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_grant),
    .o_idx        (w_pick_idx),
    .o_any        (w_req_any)
  );

  assign w_accept = (r_state == ARB_IDLE) && w_req_any;
  assign w_done   = (r_state == ARB_BUS) && !avm_waitrequest;

`ifdef AVALON_ARB_TIMEOUT_EN
  logic [AVALON_ARB_WAIT_W-1:0] r_wait_cnt;
  logic                         r_timeout_err;

  // The abort fires on the TIMEOUT_CYCLES-th stalled cycle, so read/write
  // stays up for exactly TIMEOUT_CYCLES stalled cycles.
  assign w_abort = (r_state == ARB_BUS) && avm_waitrequest &&
                   (r_wait_cnt == AVALON_ARB_WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE) begin
        r_wait_cnt <= '0;
      end else if (avm_waitrequest) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: if (w_req_any)        w_next_state = ARB_BUS;
      ARB_BUS:  if (w_done || w_abort) w_next_state = ARB_IDLE;
      default:                        w_next_state = ARB_IDLE;
    endcase
  end

  // FSM outputs: grant is only offered while idle
  always_comb begin
    grant = '0;
    if (r_state == ARB_IDLE) begin
      grant = w_pick_grant;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      if (w_accept) begin
        r_owner <= w_pick_idx;
        r_read  <= req_load[w_pick_idx];
        r_write <= !req_load[w_pick_idx];
      end else if (w_done || w_abort) begin
        r_read               <= 1'b0;
        r_write              <= 1'b0;
        r_rsp_valid[r_owner] <= 1'b1;
        r_rsp_data           <= (w_done && r_read) ? avm_readdata : '0;
        r_last_grant         <= r_owner;
      end
    end
  end

  // Address/data capture; held stable for the whole bus phase
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= w_addr_arr[w_pick_idx];
      r_be    <= w_be_arr[w_pick_idx];
      r_wdata <= w_wdata_arr[w_pick_idx];
    end
  end

  assign avm_address    = r_addr;
  assign avm_byteenable = r_be;
  assign avm_writedata  = r_wdata;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
module tb_avalon_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, req_load;
  logic [N*32-1:0]   req_addr, req_wdata;
  logic [N*4-1:0]    req_be;
  logic [N-1:0]      grant, rsp_valid;
  logic [31:0]       rsp_data;
  logic              timeout_err;
  logic [31:0]       avm_address, avm_writedata, avm_readdata;
  logic [3:0]        avm_byteenable;
  logic              avm_read, avm_write, avm_waitrequest;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference state
  bit          m_busy;
  int          m_owner;
  bit          m_isread;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_last;
  logic [N-1:0] m_rsp_valid;
  logic [31:0] m_rsp_data;
  bit          m_terr;
  int          m_wait;

  avalon_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_load(req_load), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .timeout_err(timeout_err), .avm_address(avm_address),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_read(avm_read), .avm_write(avm_write), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Next requester after 'last' in circular order that is requesting.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    int w;
    g = '0;
    if (!m_busy) begin
      w = pick(req, m_last);
      if (w >= 0) g[w] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_isread = 0; m_last = N - 1;
    m_rsp_valid = '0; m_rsp_data = '0; m_terr = 0; m_wait = 0;
  endtask

  // Apply one clock edge to the reference using the inputs currently driven.
  task automatic model_step();
    int w;
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    if (!m_busy) begin
      w = pick(req, m_last);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_isread = req_load[w]; m_wait = 0;
        m_addr = req_addr[32*w +: 32]; m_be = req_be[4*w +: 4]; m_wdata = req_wdata[32*w +: 32];
      end
    end else if (!avm_waitrequest) begin
      m_rsp_valid[m_owner] = 1'b1;
      m_rsp_data = m_isread ? avm_readdata : 32'h0;
      m_last = m_owner; m_busy = 0;
    end
`ifdef AVALON_ARB_TIMEOUT_EN
    else begin
      m_wait++;
      if (m_wait == TO) begin
        m_rsp_valid[m_owner] = 1'b1;
        m_terr = 1; m_last = m_owner; m_busy = 0;
      end
    end
`endif
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_load = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({avm_read, avm_write} !== 2'b00) begin
      errors++; $display("FAIL reset_rw: read/write=%b%b required 00", avm_read, avm_write);
    end
    checks++;
    if (rsp_valid !== '0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_rsp: rsp_valid=%b rsp_data=%h required 0/0", rsp_valid, rsp_data);
    end
    checks++;
    if (timeout_err !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL reset_misc: timeout_err=%b grant=%b required 0/0", timeout_err, grant);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 0, 1};
    int n = 0;
    req = 4'b0011; req_load = 4'b0011; avm_waitrequest = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (c % 2 == 0) begin
        if (grant !== (N'(1) << order[n])) begin
          errors++; $display("FAIL rr_order #%0d: grant=%b required %b", n, grant, N'(1) << order[n]);
        end
        n++;
      end else if (grant !== '0) begin
        errors++; $display("FAIL rr_busy_grant cyc %0d: grant=%b required 0", c, grant);
      end
      advance();
    end
    req = '0;
    advance();
  endtask

  task automatic test_wait_read();
    req = 4'b0001; req_load = 4'b0001; req_addr[31:0] = 32'h1000; req_be[3:0] = 4'hF;
    avm_waitrequest = 1'b1; avm_readdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL wr_grant: grant=%b required 0001", grant);
    end
    advance();
    req = '0; req_addr[31:0] = 32'hDEAD0000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== 32'h1000) begin
        errors++; $display("FAIL wr_hold cyc %0d: read=%b write=%b addr=%h required 1/0/00001000",
                           i, avm_read, avm_write, avm_address);
      end
      if (i == 3) avm_waitrequest = 1'b0;
      advance();
    end
    checks++;
    if (avm_read !== 1'b0 || rsp_valid !== 4'b0001 || rsp_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wr_rsp: read=%b rsp_valid=%b rsp_data=%h required 0/0001/cafef00d",
                         avm_read, rsp_valid, rsp_data);
    end
    advance();
    checks++;
    if (rsp_valid !== '0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL wr_pulse: rsp_valid=%b rsp_data=%h required 0/0", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_write();
    req = 4'b0010; req_load = 4'b0000; req_addr[63:32] = 32'h20; req_be[7:4] = 4'b0011;
    req_wdata[63:32] = 32'h1234; avm_waitrequest = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0010) begin
      errors++; $display("FAIL w_grant: grant=%b required 0010", grant);
    end
    advance();
    req = '0;
    checks++;
    if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_byteenable !== 4'b0011 ||
        avm_address !== 32'h20 || avm_writedata !== 32'h1234) begin
      errors++; $display("FAIL w_bus: write=%b read=%b be=%b addr=%h wdata=%h required 1/0/0011/20/1234",
                         avm_write, avm_read, avm_byteenable, avm_address, avm_writedata);
    end
    advance();
    checks++;
    if (avm_write !== 1'b0 || rsp_valid !== 4'b0010 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL w_rsp: write=%b rsp_valid=%b rsp_data=%h required 0/0010/0",
                         avm_write, rsp_valid, rsp_data);
    end
    advance();
  endtask

  task automatic test_async_reset();
    req = 4'b0001; req_load = 4'b0001; avm_waitrequest = 1'b1;
    advance();
    checks++;
    if (avm_read !== 1'b1) begin
      errors++; $display("FAIL ar_pre: read=%b required 1", avm_read);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (avm_read !== 1'b0 || grant !== 4'b0001) begin
      errors++; $display("FAIL ar_drop: read=%b grant=%b required 0/0001", avm_read, grant);
    end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (rsp_valid !== '0 || avm_read !== 1'b0) begin
        errors++; $display("FAIL ar_norsp cyc %0d: rsp_valid=%b read=%b required 0/0", i, rsp_valid, avm_read);
      end
    end
  endtask

  task automatic test_fairness();
    req = '1; req_load = 4'b0101; avm_waitrequest = 1'b0;
    for (int c = 0; c < 24; c++) begin
      #1;
      checks++;
      if (c % 2 == 0) begin
        if (grant !== (N'(1) << ((c / 2) % N))) begin
          errors++; $display("FAIL fair_order txn %0d: grant=%b required %b", c / 2, grant, N'(1) << ((c / 2) % N));
        end
      end else if (grant !== '0) begin
        errors++; $display("FAIL fair_busy cyc %0d: grant=%b required 0", c, grant);
      end
      advance();
    end
    req = '0;
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (avm_read !== (m_busy && m_isread) || avm_write !== (m_busy && !m_isread)) begin
        errors++; $display("FAIL rand_rw cyc %0d: read/write=%b%b required %b%b",
                           c, avm_read, avm_write, m_busy && m_isread, m_busy && !m_isread);
      end
      if (m_busy) begin
        checks++;
        if (avm_address !== m_addr || avm_byteenable !== m_be || avm_writedata !== m_wdata) begin
          errors++; $display("FAIL rand_bus cyc %0d: addr=%h be=%b wdata=%h required %h/%b/%h",
                             c, avm_address, avm_byteenable, avm_writedata, m_addr, m_be, m_wdata);
        end
      end
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data) begin
        errors++; $display("FAIL rand_rsp cyc %0d: rsp_valid=%b rsp_data=%h required %b/%h",
                           c, rsp_valid, rsp_data, m_rsp_valid, m_rsp_data);
      end
      checks++;
      if (timeout_err !== m_terr) begin
        errors++; $display("FAIL rand_terr cyc %0d: timeout_err=%b required %b", c, timeout_err, m_terr);
      end
      req      = N'($urandom);
      req_load = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[32*i +: 32]  = $urandom;
        req_wdata[32*i +: 32] = $urandom;
        req_be[4*i +: 4]      = 4'($urandom);
      end
      avm_waitrequest = ($urandom_range(0, 3) == 0);
      avm_readdata    = $urandom;
      #1;
      checks++;
      if (grant !== exp_grant()) begin
        errors++; $display("FAIL rand_grant cyc %0d: grant=%b required %b", c, grant, exp_grant());
      end
      advance();
    end
    req = '0; avm_waitrequest = 1'b0;
    advance(); advance();
  endtask

`ifdef AVALON_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req = 4'b0001; req_load = 4'b0001; avm_waitrequest = 1'b1;
    advance();
    req = '0;
    while (avm_read === 1'b1 && n < 20) begin
      n++;
      advance();
    end
    checks++;
    if (n !== TO) begin
      errors++; $display("FAIL to_len: read held %0d cycles required %0d", n, TO);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h0 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_rsp: rsp_valid=%b rsp_data=%h timeout_err=%b required 0001/0/1",
                         rsp_valid, rsp_data, timeout_err);
    end
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: timeout_err=%b required 1", timeout_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_wait_read();
    test_write();
    test_async_reset();
    test_fairness();
    test_random();
`ifdef AVALON_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
